// File: rtl/store_mailbox.sv
// Memory-mapped pass/fail mailbox beside the RV32I data memory: TOHOST/STATUS/CYCLE window,
// run cycle counter with timeout, and a FIFO log of ordinary data stores.
module store_mailbox #(
  parameter logic [31:0] BASE_ADDR      = 32'd100,
  parameter logic [31:0] PASS_VALUE     = 32'd25,
  parameter int          TIMEOUT_CYCLES = 1000,
  parameter int          LOG_DEPTH      = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_write,
  input  logic        mem_read,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  input  logic [3:0]  byte_en,
  output logic [31:0] read_data,
  output logic        hit,
  output logic        done,
  output logic        pass,
  output logic        fail,
  output logic [31:0] result,
  output logic [31:0] cycle_count,
  input  logic        log_pop,
  output logic        log_valid,
  output logic [31:0] log_addr,
  output logic [31:0] log_data,
  output logic        log_overflow
);

  localparam logic [29:0] TOHOST_W     = BASE_ADDR[31:2];
  localparam logic [29:0] STATUS_W     = TOHOST_W + 30'd1;
  localparam logic [29:0] CYCLE_W      = TOHOST_W + 30'd2;
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
  localparam int          PW           = $clog2(LOG_DEPTH);
  localparam int          CW           = $clog2(LOG_DEPTH + 1);

  typedef enum logic [1:0] {ST_RUN, ST_PASS, ST_FAIL} state_t;

  state_t        state_q, state_d;
  logic [31:0]   result_q, result_d;
  logic [31:0]   cycle_q;
  logic          is_tohost, is_status, is_cycle, tohost_sw, timeout, in_run;

  assign is_tohost = (addr[31:2] == TOHOST_W);
  assign is_status = (addr[31:2] == STATUS_W);
  assign is_cycle  = (addr[31:2] == CYCLE_W);
  assign hit       = is_tohost | is_status | is_cycle;
  assign tohost_sw = mem_write & is_tohost & (byte_en == 4'hF);
  assign timeout   = (cycle_q == TIMEOUT_LAST);
  assign in_run    = (state_q == ST_RUN);

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_RUN;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
    end
  end

  // FSM: next state; a full-word TOHOST store takes priority over the timeout
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    if (state_q == ST_RUN) begin
      if (tohost_sw) begin
        state_d  = (write_data == PASS_VALUE) ? ST_PASS : ST_FAIL;
        result_d = write_data;
      end else if (timeout) begin
        state_d  = ST_FAIL;
        result_d = 32'hFFFF_FFFF;
      end
    end
  end

  // FSM: outputs
  always_comb begin
    done = 1'b0;
    pass = 1'b0;
    fail = 1'b0;
    case (state_q)
      ST_PASS: begin done = 1'b1; pass = 1'b1; end
      ST_FAIL: begin done = 1'b1; fail = 1'b1; end
      default: ;
    endcase
  end

  assign result      = result_q;
  assign cycle_count = cycle_q;

  always_ff @(posedge clk) begin
    if (rst)                               cycle_q <= '0;
    else if (in_run && (cycle_q != '1))    cycle_q <= cycle_q + 32'd1;
  end

  // Store log
  logic [63:0]   log_mem [LOG_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] log_cnt;
  logic          log_ovf_q, push, do_push, do_pop, full, empty;

  assign full    = (log_cnt == CW'(LOG_DEPTH));
  assign empty   = (log_cnt == '0);
  assign push    = in_run & mem_write & ~is_status & ~is_cycle & ~tohost_sw;
  assign do_pop  = log_pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      log_cnt   <= '0;
      log_ovf_q <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   log_cnt <= log_cnt + CW'(1);
        2'b01:   log_cnt <= log_cnt - CW'(1);
        default: log_cnt <= log_cnt;
      endcase
      if (push && full && !do_pop) log_ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && do_push) log_mem[wr_ptr] <= {addr, write_data};
  end

  assign log_valid    = ~empty;
  assign log_addr     = log_mem[rd_ptr][63:32];
  assign log_data     = log_mem[rd_ptr][31:0];
  assign log_overflow = log_ovf_q;

  logic [31:0] cnt_ext;
  assign cnt_ext = 32'(log_cnt);

  always_comb begin
    read_data = '0;
    if (mem_read) begin
      if (is_tohost)      read_data = result_q;
      else if (is_status) read_data = {24'b0, log_ovf_q, cnt_ext[2:0], 1'b0, fail, pass, done};
      else if (is_cycle)  read_data = cycle_q;
    end
  end

  logic unused_ok;
  assign unused_ok = &{1'b0, addr[1:0], cnt_ext[31:3]};

endmodule

// File: tb/tb_store_mailbox.sv
// Directed bench for store_mailbox: vector table for run/reset/window decode, plus
// hand-written sequences for timeout, tie priority and store-log corner cases.
module tb_store_mailbox;

  logic        clk = 1'b0;
  logic        rst, mem_write, mem_read, log_pop;
  logic [31:0] addr, write_data;
  logic [3:0]  byte_en;
  logic [31:0] read_data, result, cycle_count, log_addr, log_data;
  logic        hit, done, pass, fail, log_valid, log_overflow;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q[$];

  store_mailbox #(
    .BASE_ADDR(32'd100), .PASS_VALUE(32'd25), .TIMEOUT_CYCLES(20), .LOG_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .mem_write(mem_write), .mem_read(mem_read), .addr(addr),
    .write_data(write_data), .byte_en(byte_en), .read_data(read_data), .hit(hit),
    .done(done), .pass(pass), .fail(fail), .result(result), .cycle_count(cycle_count),
    .log_pop(log_pop), .log_valid(log_valid), .log_addr(log_addr), .log_data(log_data),
    .log_overflow(log_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, mw, mr;
    logic [31:0] a, wd;
    logic [3:0]  be;
    logic        pop;
    logic        e_hit;
    logic [31:0] e_rd;
    logic        e_done, e_pass, e_fail;
    logic [31:0] e_result, e_cycle;
    logic        e_lv;
    logic [31:0] e_laddr, e_ldata;
    logic        e_ov;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic r, logic mw, logic mr, logic [31:0] a, logic [31:0] wd,
                              logic [3:0] be, logic eh, logic [31:0] erd, logic ed, logic ep,
                              logic ef, logic [31:0] eres, logic [31:0] ecyc, logic elv,
                              logic [31:0] ela, logic [31:0] eld, logic eov);
    vec_t v;
    v.rst = r; v.mw = mw; v.mr = mr; v.a = a; v.wd = wd; v.be = be; v.pop = 1'b0;
    v.e_hit = eh; v.e_rd = erd; v.e_done = ed; v.e_pass = ep; v.e_fail = ef;
    v.e_result = eres; v.e_cycle = ecyc; v.e_lv = elv; v.e_laddr = ela; v.e_ldata = eld;
    v.e_ov = eov;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic r, input logic mw, input logic mr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] be, input logic pop);
    rst = r; mem_write = mw; mem_read = mr; addr = a; write_data = wd; byte_en = be;
    log_pop = pop;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    set_in(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'h0, 1'b0);
  endtask

  task automatic do_reset();
    set_in(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 4'h0, 1'b0);
    step();
    idle();
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    set_in(1'b0, 1'b1, 1'b0, a, d, be, 1'b0);
    step();
    idle();
  endtask

  task automatic pop1();
    set_in(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'h0, 1'b1);
    step();
    idle();
  endtask

  task automatic read_status(input string name, input logic [31:0] exp);
    set_in(1'b0, 1'b0, 1'b1, 32'd104, 32'd0, 4'h0, 1'b0);
    #1;
    check(name, read_data, exp);
    step();
    idle();
  endtask

  task automatic check_flags(input string name, input logic d, input logic p, input logic f,
                             input logic [31:0] res, input logic [31:0] cyc);
    check({name, "_done"}, 32'(done), 32'(d));
    check({name, "_pass"}, 32'(pass), 32'(p));
    check({name, "_fail"}, 32'(fail), 32'(f));
    check({name, "_result"}, result, res);
    check({name, "_cycle"}, cycle_count, cyc);
  endtask

  task automatic drain(input string name);
    while (exp_q.size() > 0) begin
      check({name, "_valid"}, 32'(log_valid), 32'd1);
      check({name, "_data"}, log_data, exp_q.pop_front());
      pop1();
    end
    check({name, "_empty"}, 32'(log_valid), 32'd0);
  endtask

  initial begin
    idle();
    // rst mw mr addr wd be | hit rd | done pass fail result cycle | lv laddr ldata ov
    vq.push_back(mk(1,0,0,  0, 0,4'h0, 0,0,    0,0,0, 0,0, 0,  0, 0,0));
    vq.push_back(mk(0,0,0,  0, 0,4'h0, 0,0,    0,0,0, 0,1, 0,  0, 0,0));
    vq.push_back(mk(0,0,0,  0, 0,4'h0, 0,0,    0,0,0, 0,2, 0,  0, 0,0));
    vq.push_back(mk(0,0,1,104, 0,4'h0, 1,0,    0,0,0, 0,3, 0,  0, 0,0));
    vq.push_back(mk(0,1,0,100,25,4'h1, 1,0,    0,0,0, 0,4, 1,100,25,0));
    vq.push_back(mk(0,0,1,104, 0,4'h0, 1,32'h10,0,0,0,0,5, 1,100,25,0));
    vq.push_back(mk(0,0,1,108, 0,4'h0, 1,5,    0,0,0, 0,6, 1,100,25,0));
    vq.push_back(mk(0,1,0,104, 9,4'hF, 1,0,    0,0,0, 0,7, 1,100,25,0));
    vq.push_back(mk(0,0,1,112, 0,4'h0, 0,0,    0,0,0, 0,8, 1,100,25,0));
    vq.push_back(mk(1,1,0, 96, 3,4'hF, 0,0,    0,0,0, 0,0, 0,  0, 0,0));
    for (int c = 1; c <= 5; c++)
      vq.push_back(mk(0,0,0,0,0,4'h0, 0,0, 0,0,0, 0,32'(c), 0,0,0,0));
    vq.push_back(mk(0,1,0,100,25,4'hF, 1,0,    1,1,0,25,6, 0,  0, 0,0));
    vq.push_back(mk(0,0,1,100, 0,4'h0, 1,25,   1,1,0,25,6, 0,  0, 0,0));
    vq.push_back(mk(0,0,1,104, 0,4'h0, 1,3,    1,1,0,25,6, 0,  0, 0,0));
    vq.push_back(mk(0,1,0, 96, 7,4'hF, 0,0,    1,1,0,25,6, 0,  0, 0,0));

    for (int i = 0; i < vq.size(); i++) begin
      set_in(vq[i].rst, vq[i].mw, vq[i].mr, vq[i].a, vq[i].wd, vq[i].be, vq[i].pop);
      #1;
      check($sformatf("v%0d_hit", i), 32'(hit), 32'(vq[i].e_hit));
      check($sformatf("v%0d_rdata", i), read_data, vq[i].e_rd);
      step();
      check_flags($sformatf("v%0d", i), vq[i].e_done, vq[i].e_pass, vq[i].e_fail,
                  vq[i].e_result, vq[i].e_cycle);
      check($sformatf("v%0d_lvalid", i), 32'(log_valid), 32'(vq[i].e_lv));
      check($sformatf("v%0d_ovf", i), 32'(log_overflow), 32'(vq[i].e_ov));
      if (vq[i].e_lv) begin
        check($sformatf("v%0d_laddr", i), log_addr, vq[i].e_laddr);
        check($sformatf("v%0d_ldata", i), log_data, vq[i].e_ldata);
      end
    end
    idle();

    // Failing value, then a later passing value must not change the outcome
    do_reset();
    store(32'd100, 32'd7, 4'hF);
    check_flags("fail7", 1, 0, 1, 32'd7, 32'd1);
    store(32'd100, 32'd25, 4'hF);
    step();
    check_flags("fail7_hold", 1, 0, 1, 32'd7, 32'd1);

    // Timeout after 20 cycles in RUN
    do_reset();
    repeat (19) step();
    check_flags("pre_timeout", 0, 0, 0, 32'd0, 32'd19);
    step();
    check_flags("timeout", 1, 0, 1, 32'hFFFF_FFFF, 32'd20);
    repeat (5) step();
    check_flags("timeout_hold", 1, 0, 1, 32'hFFFF_FFFF, 32'd20);

    // TOHOST store on the timeout cycle wins
    do_reset();
    repeat (19) step();
    store(32'd100, 32'd25, 4'hF);
    check_flags("tie_pass", 1, 1, 0, 32'd25, 32'd20);

    // Overflow: five stores into a four-entry log
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      store(32'd96, 32'(k), 4'hF);
      if (k <= 4) exp_q.push_back(32'(k));
    end
    check("ovf_flag", 32'(log_overflow), 32'd1);
    check("ovf_head_addr", log_addr, 32'd96);
    read_status("ovf_status", 32'h0000_00C0);
    drain("ovf_drain");
    pop1();
    check("extra_pop_valid", 32'(log_valid), 32'd0);
    check("extra_pop_ovf", 32'(log_overflow), 32'd1);

    // Full log with simultaneous push and pop
    do_reset();
    for (int k = 10; k <= 13; k++) begin
      store(32'd200, 32'(k), 4'hF);
      exp_q.push_back(32'(k));
    end
    set_in(1'b0, 1'b1, 1'b0, 32'd204, 32'd14, 4'hF, 1'b1);
    step();
    idle();
    void'(exp_q.pop_front());
    exp_q.push_back(32'd14);
    check("pp_full_ovf", 32'(log_overflow), 32'd0);
    read_status("pp_full_status", 32'h0000_0040);
    drain("pp_full_drain");

    // Empty log with simultaneous push and pop
    set_in(1'b0, 1'b1, 1'b0, 32'd200, 32'd20, 4'hF, 1'b1);
    step();
    idle();
    check("pp_empty_valid", 32'(log_valid), 32'd1);
    check("pp_empty_data", log_data, 32'd20);
    pop1();
    check("pp_empty_drain", 32'(log_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
